// File: rtl/fpga_ram_sp_if.sv
// Single-port RAM access bus shared by the core and the memory-mapped loader.
// The master side drives the access; the slave side is the RAM.
interface fpga_ram_sp_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 15
);
    localparam int LANES = (DATA_WIDTH + 7) / 8;

    logic                  EN;
    logic [LANES-1:0]      WE;
    logic [ADDR_WIDTH-1:0] ADDR;
    logic [DATA_WIDTH-1:0] DI;
    logic                  REGCE;
    logic [DATA_WIDTH-1:0] DO;
    logic                  DO_VALID;
    logic                  BUSY;

    modport master (output EN, WE, ADDR, DI, REGCE, input DO, DO_VALID, BUSY);
    modport slave  (input EN, WE, ADDR, DI, REGCE, output DO, DO_VALID, BUSY);
endinterface

// File: rtl/fpga_ram_sp.sv
// Parametrised single-port synchronous RAM with byte-lane writes, selectable
// write mode, optional output register and a post-reset clear sweep.
//
// state | meaning
// CLEAR | zeroing one word per cycle, user accesses dropped, BUSY high
// READY | normal access, stays here until RST
module fpga_ram_sp #(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    ADDR_WIDTH     = 15,
    parameter int                    DO_REG         = 0,
    parameter int                    WRITE_MODE     = 0,
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] SRVAL          = '0
) (
    input  logic            clk,
    input  logic            RST,
    fpga_ram_sp_if.slave    bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {CLEAR, READY} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH:0]   clr_cnt;
    logic [ADDR_WIDTH:0]   clr_cnt_nxt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] lane_mask;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] wr_word;
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  s1_valid;
    logic                  acc;
    logic                  wr;

    always_ff @(posedge clk) begin
        if (RST) begin
            state <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
        end else begin
            state <= state_nxt;
        end
    end

    // Completion is flagged by the carry into the counter's extra MSB.
    always_comb begin
        clr_cnt_nxt = clr_cnt + {{ADDR_WIDTH{1'b0}}, 1'b1};
        state_nxt   = state;
        if (state == CLEAR && clr_cnt_nxt[ADDR_WIDTH]) begin
            state_nxt = READY;
        end
    end

    always_comb begin
        bus.BUSY = (state == CLEAR);
        acc      = (state == READY) && bus.EN && !RST;
        wr       = acc && (|bus.WE);
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            clr_cnt <= '0;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // The top lane simply covers whatever bits remain above the last full byte.
    always_comb begin
        lane_mask = '0;
        for (int b = 0; b < DATA_WIDTH; b++) begin
            lane_mask[b] = bus.WE[b / 8];
        end
    end

    assign rd_word = mem[bus.ADDR];
    assign wr_word = (bus.DI & lane_mask) | (rd_word & ~lane_mask);

    always_ff @(posedge clk) begin
        if (state == CLEAR && !RST) begin
            mem[clr_cnt[ADDR_WIDTH-1:0]] <= '0;
        end else if (wr) begin
            mem[bus.ADDR] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            s1_data  <= SRVAL;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= 1'b0;
            if (acc) begin
                if (!wr) begin
                    s1_data  <= rd_word;
                    s1_valid <= 1'b1;
                end else if (WRITE_MODE == 0) begin
                    s1_data  <= wr_word;
                    s1_valid <= 1'b1;
                end else if (WRITE_MODE == 1) begin
                    s1_data  <= rd_word;
                    s1_valid <= 1'b1;
                end
            end
        end
    end

    generate
        if (DO_REG != 0) begin : g_do_reg
            logic [DATA_WIDTH-1:0] s2_data;
            logic                  s2_valid;

            // Stage 2 only loads real access data, so an unloaded stage-1 word is simply lost.
            always_ff @(posedge clk) begin
                if (RST) begin
                    s2_data  <= SRVAL;
                    s2_valid <= 1'b0;
                end else begin
                    s2_valid <= bus.REGCE && s1_valid;
                    if (bus.REGCE && s1_valid) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign bus.DO       = s2_data;
            assign bus.DO_VALID = s2_valid;
        end else begin : g_no_do_reg
            assign bus.DO       = s1_data;
            assign bus.DO_VALID = s1_valid;
        end
    endgenerate
endmodule
